menu_select_controller: RTL



---
 rtl/menu_select_controller.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/menu_select_controller.sv
// menu_select_controller
//   Two-axis menu selector. Keeps an LR index (scent/item) and a UD index
//   (timer/level), each wrapping within its own item count. Indices are
//   stepped by four debounced, optionally auto-repeating push-buttons, or
//   loaded directly by a two-byte UART command (header, argument). A UART
//   load beats a button step on the same axis in the same cycle.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for a header byte (HDR_LR / HDR_UD)
//   WAIT_ARG | header seen, waiting for the argument byte or the timeout
//
// Ports
//   clk             system clock
//   reset           synchronous, active-low reset
//   btn_L / btn_R   raw buttons: decrement / increment LR
//   btn_U / btn_D   raw buttons: increment / decrement UD
//   uart_data_valid one-cycle strobe qualifying uart_data_in
//   uart_data_in    received UART byte
//   sel_lr, sel_ud  current indices
//   lr_changed      pulse in the cycle sel_lr takes a new value
//   ud_changed      pulse in the cycle sel_ud takes a new value
//   cmd_err         pulse on a rejected or timed-out UART command
module menu_select_controller #(
  parameter int          NUM_LR          = 3,
  parameter int          NUM_UD          = 3,
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter int          REPEAT_DELAY    = 0,
  parameter int          REPEAT_PERIOD   = 25000000,
  parameter int          CMD_TIMEOUT     = 1000000,
  parameter logic [7:0]  HDR_LR          = 8'h4C,
  parameter logic [7:0]  HDR_UD          = 8'h54,
  localparam int         LR_W            = (NUM_LR > 2) ? $clog2(NUM_LR) : 1,
  localparam int         UD_W            = (NUM_UD > 2) ? $clog2(NUM_UD) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_L,
  input  logic            btn_R,
  input  logic            btn_U,
  input  logic            btn_D,
  input  logic            uart_data_valid,
  input  logic [7:0]      uart_data_in,
  output logic [LR_W-1:0] sel_lr,
  output logic [UD_W-1:0] sel_ud,
  output logic            lr_changed,
  output logic            ud_changed,
  output logic            cmd_err
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(CMD_TIMEOUT + 1);
  localparam logic [LR_W-1:0] LR_MAX = LR_W'(NUM_LR - 1);
  localparam logic [UD_W-1:0] UD_MAX = UD_W'(NUM_UD - 1);

  // Button order in the vectors below: 0=L, 1=R, 2=U, 3=D.
  logic [3:0] btn_raw;
  logic [3:0] step;

  assign btn_raw = {btn_D, btn_U, btn_R, btn_L};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic            sync_a;
    logic            sync_b;
    logic            deb;
    logic            deb_d;
    logic [DB_W-1:0] db_cnt;
    logic            rep_hit;

    always_ff @(posedge clk) begin
      if (!reset) begin
        sync_a <= 1'b0;
        sync_b <= 1'b0;
        deb    <= 1'b0;
        deb_d  <= 1'b0;
        db_cnt <= '0;
      end else begin
        sync_a <= btn_raw[i];
        sync_b <= sync_a;
        deb_d  <= deb;
        // Count consecutive disagreeing cycles; a single agreeing cycle restarts.
        if (sync_b != deb) begin
          if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb    <= sync_b;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end

    if (REPEAT_DELAY > 0) begin : g_rep
      localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RP_W   = $clog2(RP_MAX + 1);
      logic [RP_W-1:0] rep_cnt;

      // Down-counter: loaded on the press edge, reloaded with the period at
      // each terminal count while the button stays debounced-high.
      always_ff @(posedge clk) begin
        if (!reset) begin
          rep_cnt <= '0;
        end else if (!deb) begin
          rep_cnt <= '0;
        end else if (!deb_d) begin
          rep_cnt <= RP_W'(REPEAT_DELAY - 1);
        end else if (rep_cnt == '0) begin
          rep_cnt <= RP_W'(REPEAT_PERIOD - 1);
        end else begin
          rep_cnt <= rep_cnt - RP_W'(1);
        end
      end

      // deb_d excludes the press cycle itself, where the counter is still clear.
      assign rep_hit = deb && deb_d && (rep_cnt == '0);
    end else begin : g_norep
      assign rep_hit = 1'b0;
    end

    assign step[i] = (deb && !deb_d) || rep_hit;
  end

  // UART command parser
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ARG = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic            axis_ud, axis_ud_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            err_nxt;
  logic            load_lr, load_ud;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      axis_ud <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      axis_ud <= axis_ud_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    axis_ud_nxt = axis_ud;
    to_cnt_nxt  = to_cnt;
    err_nxt     = 1'b0;
    load_lr     = 1'b0;
    load_ud     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (uart_data_valid) begin
          if (uart_data_in == HDR_LR) begin
            axis_ud_nxt = 1'b0;
            state_nxt   = ST_WAIT_ARG;
            to_cnt_nxt  = TO_W'(CMD_TIMEOUT - 1);
          end else if (uart_data_in == HDR_UD) begin
            axis_ud_nxt = 1'b1;
            state_nxt   = ST_WAIT_ARG;
            to_cnt_nxt  = TO_W'(CMD_TIMEOUT - 1);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_ARG: begin
        // An argument arriving on the last allowed cycle still wins over the timeout.
        if (uart_data_valid) begin
          state_nxt = ST_IDLE;
          if (!axis_ud) begin
            if ({1'b0, uart_data_in} < 9'(NUM_LR)) load_lr = 1'b1;
            else                                   err_nxt = 1'b1;
          end else begin
            if ({1'b0, uart_data_in} < 9'(NUM_UD)) load_ud = 1'b1;
            else                                   err_nxt = 1'b1;
          end
        end else if (to_cnt == '0) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt - TO_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Axis update: UART load, then increment button, then decrement button.
  logic [LR_W-1:0] lr_nxt;
  logic [UD_W-1:0] ud_nxt;
  logic            lr_chg_nxt, ud_chg_nxt;
  logic [LR_W-1:0] lr_arg;
  logic [UD_W-1:0] ud_arg;

  assign lr_arg = uart_data_in[LR_W-1:0];
  assign ud_arg = uart_data_in[UD_W-1:0];

  always_comb begin
    lr_nxt     = sel_lr;
    lr_chg_nxt = 1'b0;
    if (load_lr) begin
      lr_nxt     = lr_arg;
      lr_chg_nxt = (lr_arg != sel_lr);
    end else if (step[1]) begin
      lr_nxt     = (sel_lr == LR_MAX) ? '0 : sel_lr + LR_W'(1);
      lr_chg_nxt = 1'b1;
    end else if (step[0]) begin
      lr_nxt     = (sel_lr == '0) ? LR_MAX : sel_lr - LR_W'(1);
      lr_chg_nxt = 1'b1;
    end
  end

  always_comb begin
    ud_nxt     = sel_ud;
    ud_chg_nxt = 1'b0;
    if (load_ud) begin
      ud_nxt     = ud_arg;
      ud_chg_nxt = (ud_arg != sel_ud);
    end else if (step[2]) begin
      ud_nxt     = (sel_ud == UD_MAX) ? '0 : sel_ud + UD_W'(1);
      ud_chg_nxt = 1'b1;
    end else if (step[3]) begin
      ud_nxt     = (sel_ud == '0) ? UD_MAX : sel_ud - UD_W'(1);
      ud_chg_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_lr     <= '0;
      sel_ud     <= '0;
      lr_changed <= 1'b0;
      ud_changed <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      sel_lr     <= lr_nxt;
      sel_ud     <= ud_nxt;
      lr_changed <= lr_chg_nxt;
      ud_changed <= ud_chg_nxt;
      cmd_err    <= err_nxt;
    end
  end

endmodule
